// File: rtl/pipes.sv
// Shared pipeline types for the memory stage: access sizes, FSM states and
// the byte-strobe helper used when issuing stores.
package pipes;

  typedef enum logic [1:0] {
    MS_BYTE  = 2'd0,
    MS_HALF  = 2'd1,
    MS_WORD  = 2'd2,
    MS_DWORD = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

  localparam int MAX_BYTES = 8;

  // Strobe for the widest datapath; narrower callers keep the low XLEN/8 bits,
  // which is safe because aligned accesses never spill past the word.
  function automatic logic [MAX_BYTES-1:0] mem_strobe(input msize_t size,
                                                      input logic [2:0] off);
    logic [MAX_BYTES:0] ones;
    ones = (9'd1 << (4'd1 << size)) - 9'd1;
    return ones[MAX_BYTES-1:0] << off;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load-data alignment: shift the addressed lane down, keep 8<<size bits and
// sign- or zero-extend to XLEN. Purely combinational.
module load_extend
  import pipes::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]             rawData,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  msize_t                      size,
  input  logic                        isUnsigned,
  output logic [XLEN-1:0]             result
);

  localparam int IDX_W = $clog2(XLEN);

  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  hiMask;
  logic [6:0]       widthBits;
  logic [IDX_W-1:0] topIdx;
  logic             signFill;

  // A full-width access shifts hiMask to zero, so no size needs a special case.
  always_comb begin
    shifted   = rawData >> {off, 3'b000};
    widthBits = 7'd8 << size;
    hiMask    = {XLEN{1'b1}} << widthBits;
    topIdx    = IDX_W'(widthBits - 7'd1);
    signFill  = ~isUnsigned & shifted[topIdx];
    result    = (shifted & ~hiMask) | (signFill ? hiMask : '0);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage between execute and writeback: issues aligned loads/stores with
// valid/ready on both sides, flags misaligned accesses, passes ALU results through.
module mem_access_unit
  import pipes::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_is_load,
  input  logic               in_is_store,
  input  logic [1:0]         in_size,
  input  logic               in_unsigned,
  input  logic [XLEN-1:0]    in_addr,
  input  logic [XLEN-1:0]    in_wdata,
  input  logic [4:0]         in_dst,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               req_valid,
  output logic [XLEN-1:0]    req_addr,
  output logic [2:0]         req_size,
  output logic [XLEN/8-1:0]  req_strobe,
  output logic [XLEN-1:0]    req_data,
  input  logic               resp_addr_ok,
  input  logic               resp_data_ok,
  input  logic [XLEN-1:0]    resp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [4:0]         out_dst,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_misalign
);

  localparam int OFF_W  = $clog2(XLEN/8);
  localparam int NBYTES = XLEN/8;

  mem_state_t state, stateNext, acceptTarget;
  logic killed, killedNext;
  logic accept, capture;
  logic inIsMem, inMisalign;
  logic [2:0] alignMask;
  logic [MAX_BYTES-1:0] fullStrobe;

  msize_t           rSize;
  logic [OFF_W-1:0] rOff;
  logic             rUnsigned;
  logic             rIsLoad;
  logic [XLEN-1:0]  loadValue;

  // Decode of the incoming instruction.
  always_comb begin
    inIsMem      = in_is_load | in_is_store;
    alignMask    = 3'((4'd1 << in_size) - 4'd1);
    inMisalign   = (in_size > 2'(OFF_W)) || (|(in_addr[2:0] & alignMask));
    fullStrobe   = mem_strobe(msize_t'(in_size), in_addr[2:0]);
    acceptTarget = (inIsMem && !inMisalign) ? REQ : HOLD;
  end

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      killed <= 1'b0;
    end else begin
      state  <= stateNext;
      killed <= killedNext;
    end
  end

  // Next-state logic. Once the bus has taken a request it cannot be recalled,
  // so a late flush only marks the entry killed and waits for the data phase.
  always_comb begin
    stateNext  = state;
    killedNext = killed;
    unique case (state)
      IDLE: if (accept) stateNext = acceptTarget;
      HOLD: begin
        if (flush)          stateNext = IDLE;
        else if (accept)    stateNext = acceptTarget;
        else if (out_ready) stateNext = IDLE;
      end
      REQ: begin
        if (resp_addr_ok) begin
          if (resp_data_ok) begin
            stateNext = flush ? IDLE : HOLD;
          end else begin
            stateNext  = WAIT;
            killedNext = flush;
          end
        end else if (flush) begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        if (resp_data_ok) begin
          stateNext  = (killed || flush) ? IDLE : HOLD;
          killedNext = 1'b0;
        end else if (flush) begin
          killedNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: each signal written here gets a default first so no latch is inferred.
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      IDLE:    in_ready = !reset;
      HOLD:    in_ready = !reset && out_ready;
      default: in_ready = 1'b0;
    endcase
    accept  = in_valid && in_ready && !flush;
    capture = resp_data_ok && !killed && !flush &&
              ((state == REQ && resp_addr_ok) || state == WAIT);
  end

  load_extend #(.XLEN(XLEN)) u_loadExtend (
    .rawData    (resp_data),
    .off        (rOff),
    .size       (rSize),
    .isUnsigned (rUnsigned),
    .result     (loadValue)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rSize        <= MS_BYTE;
      rOff         <= '0;
      rUnsigned    <= 1'b0;
      rIsLoad      <= 1'b0;
      req_valid    <= 1'b0;
      req_addr     <= '0;
      req_size     <= '0;
      req_strobe   <= '0;
      req_data     <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_dst      <= '0;
      out_tag      <= '0;
      out_misalign <= 1'b0;
    end else begin
      req_valid <= (stateNext == REQ);
      out_valid <= (stateNext == HOLD);
      if (accept) begin
        rSize        <= msize_t'(in_size);
        rOff         <= in_addr[OFF_W-1:0];
        rUnsigned    <= in_unsigned;
        rIsLoad      <= in_is_load;
        out_dst      <= in_dst;
        out_tag      <= in_tag;
        out_misalign <= inIsMem && inMisalign;
        out_result   <= inIsMem ? '0 : in_addr;
        if (inIsMem && !inMisalign) begin
          req_addr   <= in_addr;
          req_size   <= {1'b0, in_size};
          req_strobe <= in_is_store ? fullStrobe[NBYTES-1:0] : '0;
          req_data   <= in_wdata << {in_addr[OFF_W-1:0], 3'b000};
        end
      end else if (capture) begin
        out_result <= rIsLoad ? loadValue : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=64) against an arithmetic
// reference model of lane selection, strobes and extension.
module tb_mem_access_unit;

  localparam int XLEN  = 64;
  localparam int TAG_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_is_load, in_is_store, in_unsigned;
  logic [1:0]        in_size;
  logic [XLEN-1:0]   in_addr, in_wdata;
  logic [4:0]        in_dst;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              req_valid;
  logic [XLEN-1:0]   req_addr, req_data;
  logic [2:0]        req_size;
  logic [XLEN/8-1:0] req_strobe;
  logic              resp_addr_ok, resp_data_ok;
  logic [XLEN-1:0]   resp_data;
  logic              out_valid, out_ready, out_misalign;
  logic [XLEN-1:0]   out_result;
  logic [4:0]        out_dst;
  logic [TAG_W-1:0]  out_tag;

  int nCompared   = 0;
  int nMismatched = 0;

  mem_access_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_dst(in_dst), .in_tag(in_tag),
    .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
    .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dst(out_dst), .out_tag(out_tag), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_is_load = 0; in_is_store = 0; in_size = 0; in_unsigned = 0;
    in_addr = 0; in_wdata = 0; in_dst = 0; in_tag = 0; flush = 0;
    resp_addr_ok = 0; resp_data_ok = 0; resp_data = 0; out_ready = 1;
  endtask

  // Reference model: byte lanes covered by an access of 2^size bytes at off.
  function automatic logic [7:0] exp_strobe(input int size, input int off);
    logic [7:0] s = 8'h00;
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + (1 << size)) s[b] = 1'b1;
    return s;
  endfunction

  // Reference model: take 2^size bytes starting at byte off, interpret as an
  // unsigned or two's-complement number, and represent it in 64 bits.
  function automatic logic [63:0] exp_load(input logic [63:0] raw, input int size,
                                           input int off, input bit uns);
    int nb = 1 << size;
    logic [63:0] v = raw >> (8 * off);
    if (nb < 8) begin
      logic [63:0] lim = 64'd1 << (8 * nb);
      v = v % lim;
      if (!uns && v >= lim / 2) v = v - lim;
    end
    return v;
  endfunction

  task automatic check_ready(input string name);
    nCompared++;
    if (in_ready !== 1'b1) begin
      nMismatched++;
      $display("FAIL %s in_ready: got %b want 1", name, in_ready);
    end
  endtask

  task automatic drive(input bit isLoad, input bit isStore, input int size, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [4:0] dst, input logic [31:0] tag);
    in_valid = 1; in_is_load = isLoad; in_is_store = isStore; in_size = 2'(size);
    in_unsigned = uns; in_addr = addr; in_wdata = wdata; in_dst = dst; in_tag = tag;
  endtask

  task automatic undrive();
    in_valid = 0; in_is_load = 0; in_is_store = 0;
  endtask

  // One complete memory transaction with a scripted bus latency.
  task automatic do_mem(input string name, input bit isStore, input int size, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] raw, input int addrDelay, input int dataDelay);
    int off = int'(addr[2:0]);
    logic [4:0]  dst = 5'($urandom);
    logic [31:0] tag = $urandom;
    logic [63:0] expRes  = isStore ? 64'd0 : exp_load(raw, size, off, uns);
    logic [7:0]  expStb  = isStore ? exp_strobe(size, off) : 8'h00;
    logic [63:0] expData = wdata << (8 * off);
    logic [139:0] expReq = {1'b1, addr, 3'(size), expStb, expData};
    check_ready(name);
    drive(!isStore, isStore, size, uns, addr, wdata, dst, tag);
    tick();
    undrive();
    for (int i = 0; i <= addrDelay; i++) begin
      nCompared++;
      if ({req_valid, req_addr, req_size, req_strobe, req_data} !== expReq || out_valid !== 1'b0) begin
        nMismatched++;
        $display("FAIL %s request cycle %0d: got %h/%b want %h/0", name, i,
                 {req_valid, req_addr, req_size, req_strobe, req_data}, out_valid, expReq);
      end
      if (i < addrDelay) tick();
    end
    resp_addr_ok = 1;
    resp_data_ok = (dataDelay == 0);
    resp_data = (dataDelay == 0) ? raw : {$urandom, $urandom};
    tick();
    resp_addr_ok = 0; resp_data_ok = 0;
    for (int i = 0; i < dataDelay; i++) begin
      nCompared++;
      if (req_valid !== 1'b0 || out_valid !== 1'b0) begin
        nMismatched++;
        $display("FAIL %s wait cycle %0d: req_valid=%b out_valid=%b want 0/0", name, i, req_valid, out_valid);
      end
      if (i == dataDelay - 1) begin
        resp_data_ok = 1; resp_data = raw;
      end else begin
        resp_data = {$urandom, $urandom};
      end
      tick();
      resp_data_ok = 0;
    end
    nCompared++;
    if ({out_valid, out_misalign, req_valid, out_result, out_dst, out_tag} !== {3'b100, expRes, dst, tag}) begin
      nMismatched++;
      $display("FAIL %s result: got v=%b m=%b rq=%b res=%h dst=%h tag=%h want res=%h dst=%h tag=%h",
               name, out_valid, out_misalign, req_valid, out_result, out_dst, out_tag, expRes, dst, tag);
    end
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (2) tick();
    nCompared++;
    if ({in_ready, req_valid, req_addr, req_strobe, req_data, out_valid, out_result, out_misalign} !== '0) begin
      nMismatched++;
      $display("FAIL reset_values: in_ready=%b req_valid=%b out_valid=%b out_result=%h want all 0",
               in_ready, req_valid, out_valid, out_result);
    end
    reset = 0;
    #1;
    check_ready("reset_release");
  endtask

  task automatic test_passthrough();
    check_ready("pass");
    drive(0, 0, 0, 0, 64'h1234, 64'h0, 5'd7, 32'hA5A5_0001);
    tick();
    undrive();
    nCompared++;
    if ({out_valid, out_misalign, req_valid, out_result, out_dst, out_tag} !== {3'b100, 64'h1234, 5'd7, 32'hA5A5_0001}) begin
      nMismatched++;
      $display("FAIL pass: got v=%b m=%b rq=%b res=%h dst=%h tag=%h want 1/0/0 res=1234",
               out_valid, out_misalign, req_valid, out_result, out_dst, out_tag);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs[8];
    logic [4:0]  dsts[8];
    logic [31:0] tags[8];
    for (int i = 0; i < 8; i++) begin
      addrs[i] = {$urandom, $urandom}; dsts[i] = 5'($urandom); tags[i] = $urandom;
    end
    check_ready("b2b_start");
    drive(0, 0, $urandom_range(0, 3), 0, addrs[0], 64'h0, dsts[0], tags[0]);
    for (int i = 0; i < 8; i++) begin
      tick();
      nCompared++;
      if ({out_valid, out_result, out_dst, out_tag, in_ready} !== {1'b1, addrs[i], dsts[i], tags[i], 1'b1}) begin
        nMismatched++;
        $display("FAIL b2b[%0d]: got v=%b res=%h dst=%h tag=%h rdy=%b want res=%h dst=%h tag=%h",
                 i, out_valid, out_result, out_dst, out_tag, in_ready, addrs[i], dsts[i], tags[i]);
      end
      if (i < 7) drive(0, 0, $urandom_range(0, 3), 0, addrs[i+1], 64'h0, dsts[i+1], tags[i+1]);
      else undrive();
    end
    tick();
  endtask

  task automatic test_backpressure();
    check_ready("bp");
    drive(0, 0, 0, 0, 64'hCAFE, 64'h0, 5'd3, 32'h1);
    out_ready = 0;
    tick();
    drive(0, 0, 0, 0, 64'hF00D, 64'h0, 5'd4, 32'h2);
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if ({out_valid, out_result, in_ready} !== {1'b1, 64'hCAFE, 1'b0}) begin
        nMismatched++;
        $display("FAIL bp stall %0d: got v=%b res=%h rdy=%b want 1/cafe/0", i, out_valid, out_result, in_ready);
      end
      tick();
    end
    out_ready = 1;
    #1;
    check_ready("bp_release");
    tick();
    undrive();
    nCompared++;
    if ({out_valid, out_result, out_dst} !== {1'b1, 64'hF00D, 5'd4}) begin
      nMismatched++;
      $display("FAIL bp next: got v=%b res=%h dst=%h want 1/f00d/4", out_valid, out_result, out_dst);
    end
    tick();
  endtask

  task automatic test_misalign();
    logic [63:0] addrs[5] = '{64'h1002, 64'h1001, 64'h1004, 64'h1003, 64'h1007};
    int          sizes[5] = '{2, 1, 3, 2, 1};
    for (int i = 0; i < 5; i++) begin
      check_ready("misalign");
      drive(i % 2 == 0, i % 2 == 1, sizes[i], 0, addrs[i], {$urandom, $urandom}, 5'd9, 32'h0);
      tick();
      undrive();
      nCompared++;
      if ({req_valid, out_valid, out_misalign, out_result} !== {3'b011, 64'h0}) begin
        nMismatched++;
        $display("FAIL misalign[%0d]: got rq=%b v=%b m=%b res=%h want 0/1/1/0",
                 i, req_valid, out_valid, out_misalign, out_result);
      end
      tick();
    end
  endtask

  task automatic test_random_mem();
    for (int i = 0; i < 24; i++) begin
      int size = $urandom_range(0, 3);
      logic [63:0] addr = {$urandom, $urandom};
      addr = addr & ~((64'd1 << size) - 64'd1);
      do_mem("random_mem", $urandom_range(0, 1), size, $urandom_range(0, 1), addr,
             {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_flush_req();
    check_ready("flush_req");
    drive(1, 0, 3, 0, 64'h3000, 64'h0, 5'd1, 32'h0);
    tick();
    undrive();
    flush = 1;
    tick();
    flush = 0;
    nCompared++;
    if ({req_valid, out_valid, in_ready} !== 3'b001) begin
      nMismatched++;
      $display("FAIL flush_req: got rq=%b v=%b rdy=%b want 0/0/1", req_valid, out_valid, in_ready);
    end
  endtask

  task automatic test_flush_wait();
    check_ready("flush_wait");
    drive(1, 0, 3, 0, 64'h2000, 64'h0, 5'd2, 32'h0);
    tick();
    undrive();
    resp_addr_ok = 1;
    tick();
    resp_addr_ok = 0;
    flush = 1;
    nCompared++;
    if (req_valid !== 1'b0) begin
      nMismatched++;
      $display("FAIL flush_wait req: got %b want 0", req_valid);
    end
    tick();
    flush = 0;
    for (int i = 0; i < 2; i++) begin
      nCompared++;
      if ({req_valid, out_valid, in_ready} !== 3'b000) begin
        nMismatched++;
        $display("FAIL flush_wait killed %0d: got rq=%b v=%b rdy=%b want 0/0/0", i, req_valid, out_valid, in_ready);
      end
      if (i == 1) begin
        resp_data_ok = 1; resp_data = {$urandom, $urandom};
      end
      tick();
    end
    resp_data_ok = 0;
    for (int i = 0; i < 2; i++) begin
      nCompared++;
      if ({req_valid, out_valid, in_ready} !== 3'b001) begin
        nMismatched++;
        $display("FAIL flush_wait done %0d: got rq=%b v=%b rdy=%b want 0/0/1", i, req_valid, out_valid, in_ready);
      end
      tick();
    end
  endtask

  task automatic test_flush_accept();
    check_ready("flush_accept");
    drive(0, 0, 0, 0, 64'h55, 64'h0, 5'd5, 32'h0);
    flush = 1;
    tick();
    undrive();
    flush = 0;
    nCompared++;
    if ({out_valid, req_valid} !== 2'b00) begin
      nMismatched++;
      $display("FAIL flush_accept: got v=%b rq=%b want 0/0", out_valid, req_valid);
    end
    drive(0, 0, 0, 0, 64'h66, 64'h0, 5'd6, 32'h0);
    out_ready = 0;
    tick();
    undrive();
    flush = 1;
    tick();
    flush = 0;
    out_ready = 1;
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++;
      $display("FAIL flush_hold: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_wait();
    check_ready("reset_wait");
    drive(1, 0, 2, 0, 64'h4000, 64'h0, 5'd8, 32'hDEAD);
    tick();
    undrive();
    resp_addr_ok = 1;
    tick();
    resp_addr_ok = 0;
    #2;
    reset = 1;
    #1;
    nCompared++;
    if ({in_ready, req_valid, req_addr, req_strobe, out_valid, out_result, out_dst, out_tag, out_misalign} !== '0) begin
      nMismatched++;
      $display("FAIL reset_wait: rdy=%b rq=%b addr=%h v=%b res=%h dst=%h tag=%h want all 0",
               in_ready, req_valid, req_addr, out_valid, out_result, out_dst, out_tag);
    end
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    do_mem("after_reset", 0, 1, 0, 64'h5002, 64'h0, 64'h0000_0000_8001_0000, 1, 1);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_back_to_back();
    test_backpressure();
    do_mem("load_byte_signed",   0, 0, 0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0);
    do_mem("load_byte_unsigned", 0, 0, 1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1, 2);
    do_mem("store_half",         1, 1, 0, 64'h1006, 64'hBEEF, 64'h0, 3, 1);
    do_mem("load_word_hi",       0, 2, 0, 64'h1004, 64'h0, 64'h8765_4321_0000_0000, 0, 3);
    test_misalign();
    test_random_mem();
    test_flush_req();
    test_flush_wait();
    test_flush_accept();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
